// File: rtl/edge_packet_fifo_if.sv
// Packet stream bundle between the SRAM packet controller, edge_packet_fifo
// and the Edge PE array: inbound packet, backpressure flags, per-PE dispatch.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif

interface edge_packet_fifo_if #(
  parameter int PKT_W = `PACKET_SIZE,
  parameter int N_PE  = `Num_Edge_PE
);
  logic                       mem2fifo_valid;
  logic [PKT_W-1:0]           mem2fifo_data;
  logic                       full;
  logic                       empty;
  logic [N_PE-1:0]            PE_ready;
  logic [N_PE-1:0]            fifo2PE_valid;
  logic [N_PE-1:0][PKT_W-1:0] fifo2PE_data;

  modport master (
    output mem2fifo_valid, mem2fifo_data, PE_ready,
    input  full, empty, fifo2PE_valid, fifo2PE_data
  );

  modport slave (
    input  mem2fifo_valid, mem2fifo_data, PE_ready,
    output full, empty, fifo2PE_valid, fifo2PE_data
  );
endinterface

// File: rtl/edge_packet_fifo.sv
// Circular packet FIFO feeding the Edge PE array round-robin, one packet per cycle.
// Optional statistics (rx/tx counters, sticky overflow) under EDGE_PACKET_FIFO_STATS_EN.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif

module edge_packet_fifo_port #(
  parameter int PKT_W = `PACKET_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PKT_W-1:0] din,
  output logic             vld,
  output logic [PKT_W-1:0] dout
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      dout <= '0;
    end else begin
      vld  <= load;
      dout <= load ? din : '0;
    end
  end
endmodule

module edge_packet_fifo #(
  parameter int DEPTH = 16,
  parameter int SKID  = 2,
  parameter int N_PE  = `Num_Edge_PE,
  parameter int PKT_W = `PACKET_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            replay_iter_flag,
  edge_packet_fifo_if.slave bus
`ifdef EDGE_PACKET_FIFO_STATS_EN
  ,
  output logic [15:0]     rx_count,
  output logic [15:0]     tx_count,
  output logic            overflow
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (N_PE > 1) ? $clog2(N_PE) : 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [RR_W-1:0]  rr_ptr, sel, rr_next;
  logic             found;
  logic             push, dispatch, drop;
  logic [N_PE-1:0]  port_load;
  int               idx;

  // Flush wins over both operations in the same cycle.
  assign push     = bus.mem2fifo_valid && (count != CNT_W'(DEPTH)) && !replay_iter_flag;
  assign dispatch = (count != '0) && (|bus.PE_ready) && !replay_iter_flag;
  assign drop     = bus.mem2fifo_valid && (count == CNT_W'(DEPTH)) && !replay_iter_flag;

  assign bus.full  = (count >= CNT_W'(DEPTH - SKID));
  assign bus.empty = (count == '0);

  // First ready PE at or after rr_ptr, wrapping past N_PE-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_PE; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_PE) idx = idx - N_PE;
      if (!found && bus.PE_ready[idx]) begin
        found = 1'b1;
        sel   = RR_W'(idx);
      end
    end
  end

  assign rr_next = (sel == RR_W'(N_PE - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    port_load = '0;
    if (dispatch) port_load[sel] = 1'b1;
  end

  // Array contents are intentionally not reset or flushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mem2fifo_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else if (replay_iter_flag) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (dispatch) begin
        rd_ptr <= rd_ptr + 1'b1;
        rr_ptr <= rr_next;
      end
      case ({push, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < N_PE; i++) begin : g_port
    logic             vld;
    logic [PKT_W-1:0] dout;
    edge_packet_fifo_port #(.PKT_W(PKT_W)) u_port (
      .clk  (clk),
      .reset(reset),
      .load (port_load[i]),
      .din  (mem[rd_ptr]),
      .vld  (vld),
      .dout (dout)
    );
    assign bus.fifo2PE_valid[i] = vld;
    assign bus.fifo2PE_data[i]  = dout;
  end

`ifdef EDGE_PACKET_FIFO_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count <= '0;
      tx_count <= '0;
      overflow <= 1'b0;
    end else if (replay_iter_flag) begin
      rx_count <= '0;
      tx_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)     rx_count <= rx_count + 1'b1;
      if (dispatch) tx_count <= tx_count + 1'b1;
      if (drop)     overflow <= 1'b1;
    end
  end
`else
  // Without statistics a full-FIFO push is discarded silently.
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_edge_packet_fifo.sv
// Randomized + directed bench for edge_packet_fifo against a queue-based model.
module tb_edge_packet_fifo;
  localparam int DEPTH = 16;
  localparam int SKID  = 2;
  localparam int NPE   = 4;
  localparam int PW    = 32;

  logic clk = 1'b0;
  logic reset;
  logic replay_iter_flag;
  int   vectors = 0;
  int   miscompares = 0;

  edge_packet_fifo_if #(.PKT_W(PW), .N_PE(NPE)) bus ();

`ifdef EDGE_PACKET_FIFO_STATS_EN
  logic [15:0] rx_count, tx_count;
  logic        overflow;
`endif

  edge_packet_fifo #(.DEPTH(DEPTH), .SKID(SKID), .N_PE(NPE), .PKT_W(PW)) dut (
    .clk             (clk),
    .reset           (reset),
    .replay_iter_flag(replay_iter_flag),
    .bus             (bus)
`ifdef EDGE_PACKET_FIFO_STATS_EN
    ,
    .rx_count        (rx_count),
    .tx_count        (tx_count),
    .overflow        (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet queue plus a round-robin start index.
  logic [PW-1:0]  q[$];
  int             m_rr;
  logic [NPE-1:0] exp_v;
  logic [PW-1:0]  exp_d [NPE];
  logic [15:0]    m_rx, m_tx;
  bit             m_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_rr = 0; m_rx = 0; m_tx = 0; m_ovf = 0;
      exp_v = '0;
      for (int i = 0; i < NPE; i++) exp_d[i] = '0;
    end else begin
      exp_v = '0;
      for (int i = 0; i < NPE; i++) exp_d[i] = '0;
      if (replay_iter_flag) begin
        q.delete();
        m_rr = 0; m_rx = 0; m_tx = 0; m_ovf = 0;
      end else begin
        int sz;
        sz = q.size();
        if (sz != 0 && bus.PE_ready != '0) begin
          for (int k = 0; k < NPE; k++) begin
            int p;
            p = (m_rr + k) % NPE;
            if (bus.PE_ready[p] && exp_v == '0) begin
              exp_v[p] = 1'b1;
              exp_d[p] = q.pop_front();
              m_rr = (p + 1) % NPE;
              m_tx++;
            end
          end
        end
        if (bus.mem2fifo_valid) begin
          if (sz < DEPTH) begin
            q.push_back(bus.mem2fifo_data);
            m_rx++;
          end else m_ovf = 1;
        end
      end
      #2;
      chk("full", 64'(bus.full), 64'(q.size() >= DEPTH - SKID));
      chk("empty", 64'(bus.empty), 64'(q.size() == 0));
      chk("fifo2PE_valid", 64'(bus.fifo2PE_valid), 64'(exp_v));
      for (int i = 0; i < NPE; i++) chk($sformatf("fifo2PE_data[%0d]", i),
                                        64'(bus.fifo2PE_data[i]), 64'(exp_d[i]));
`ifdef EDGE_PACKET_FIFO_STATS_EN
      chk("rx_count", 64'(rx_count), 64'(m_rx));
      chk("tx_count", 64'(tx_count), 64'(m_tx));
      chk("overflow", 64'(overflow), 64'(m_ovf));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [PW-1:0] d);
    bus.mem2fifo_valid = 1'b1;
    bus.mem2fifo_data  = d;
    step();
    bus.mem2fifo_valid = 1'b0;
  endtask

  task automatic flush();
    replay_iter_flag = 1'b1;
    step();
    replay_iter_flag = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    replay_iter_flag = 1'b0;
    bus.mem2fifo_valid = 1'b0;
    bus.mem2fifo_data  = '0;
    bus.PE_ready       = '0;
    step(); step();
    chk("reset_full", 64'(bus.full), 64'd0);
    chk("reset_empty", 64'(bus.empty), 64'd1);
    chk("reset_valid", 64'(bus.fifo2PE_valid), 64'd0);
    reset = 1'b1;

    // Three pushes with no PE ready
    for (int i = 1; i <= 3; i++) push(PW'(i));
    chk("t1_empty", 64'(bus.empty), 64'd0);
    chk("t1_full", 64'(bus.full), 64'd0);
    chk("t1_valid", 64'(bus.fifo2PE_valid), 64'd0);

    // Fill to the skid threshold, then into the skid, then overflow
    for (int i = 4; i <= 13; i++) push(PW'(i));
    chk("t2_full_13", 64'(bus.full), 64'd0);
    push(32'd14);
    chk("t2_full_14", 64'(bus.full), 64'd1);
    push(32'd15);
    push(32'd16);
    chk("t2_full_16", 64'(bus.full), 64'd1);
    push(32'd17);
`ifdef EDGE_PACKET_FIFO_STATS_EN
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_rx", 64'(rx_count), 64'd16);
`endif
    bus.PE_ready = 4'b1111;
    n = 0;
    while (!bus.empty && n < 40) begin step(); n++; end
    chk("t2_drained", 64'(bus.empty), 64'd1);
    bus.PE_ready = '0;
    flush();

    // Round-robin over all ready PEs
    for (int i = 0; i < 5; i++) push(32'hA0 + PW'(i));
    bus.PE_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_port", 64'(bus.fifo2PE_valid), 64'(1 << (k % 4)));
      chk("t3_data", 64'(bus.fifo2PE_data[k % 4]), 64'(32'hA0 + k));
    end
    step();
    chk("t3_idle", 64'(bus.fifo2PE_valid), 64'd0);
    bus.PE_ready = '0;
    flush();

    // Single ready PE 2 from rr_ptr 0, then rr_ptr must be 3
    bus.PE_ready = 4'b0100;
    push(32'hB0);
    step();
    chk("t4_port", 64'(bus.fifo2PE_valid), 64'b0100);
    chk("t4_data", 64'(bus.fifo2PE_data[2]), 64'hB0);
    bus.PE_ready = '0;
    push(32'hB1);
    bus.PE_ready = 4'b1111;
    step();
    chk("t4_rr", 64'(bus.fifo2PE_valid), 64'b1000);
    bus.PE_ready = '0;

    // Steady state at five entries across pointer wrap
    for (int i = 0; i < 5; i++) push(32'hC0 + PW'(i));
    bus.PE_ready = 4'b1111;
    for (int i = 0; i < 40; i++) push(32'hD00 + PW'(i));
    bus.PE_ready = '0;
    chk("t5_full", 64'(bus.full), 64'd0);
    chk("t5_empty", 64'(bus.empty), 64'd0);

    // Flush at seven entries with a simultaneous push
    push(32'hE0);
    push(32'hE1);
    replay_iter_flag = 1'b1;
    bus.mem2fifo_valid = 1'b1;
    bus.mem2fifo_data  = 32'hEE;
    step();
    replay_iter_flag = 1'b0;
    bus.mem2fifo_valid = 1'b0;
    chk("t6_empty", 64'(bus.empty), 64'd1);
    chk("t6_valid", 64'(bus.fifo2PE_valid), 64'd0);
    bus.PE_ready = 4'b1111;
    step();
    chk("t6_not_stored", 64'(bus.fifo2PE_valid), 64'd0);

    // Randomized traffic with occasional flushes and one mid-stream reset
    for (int i = 0; i < 1200; i++) begin
      bus.mem2fifo_valid = ($urandom_range(0, 99) < 65);
      bus.mem2fifo_data  = $urandom;
      bus.PE_ready       = (i % 300 < 150) ? NPE'($urandom & $urandom & $urandom) : NPE'($urandom);
      replay_iter_flag   = ($urandom_range(0, 199) == 0);
      if (i == 700) begin
        reset = 1'b0;
        #1;
        chk("mid_reset_empty", 64'(bus.empty), 64'd1);
        chk("mid_reset_valid", 64'(bus.fifo2PE_valid), 64'd0);
        chk("mid_reset_full", 64'(bus.full), 64'd0);
        step();
        reset = 1'b1;
      end
      step();
    end
    replay_iter_flag = 1'b0;
    bus.mem2fifo_valid = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/edge_packet_fifo.md
# edge_packet_fifo

- Receive side of the packet stream produced by the packet controller.
- Buffers packets delivered on `mem2fifo` in a circular FIFO and returns `full` to throttle the controller's SRAM reads.
- Dispatches buffered packets, one per cycle, round-robin to ready Edge PEs.
- Sits between the packet SRAM controller and the `Num_Edge_PE` Edge PE array.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `SKID`, 2: entries reserved for packets already in flight when `full` rises.
- `N_PE`, `` `Num_Edge_PE``: number of dispatch ports.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `replay_iter_flag`  in  1  — synchronous flush; same-cycle push and dispatch are suppressed.
- `mem2fifo`  in  `com_packet` (`valid` + `` `packet_size`` packet)  — incoming packet.
- `full`  out  1  — backpressure to the packet controller.
- `empty`  out  1  — `count == 0`.
- `PE_ready`  in  `N_PE`  — bit i high: Edge PE i accepts a packet this cycle.
- `fifo2PE`  out  `N_PE` × `com_packet`  — registered per-PE packet, valid for one cycle.

## Operation
Storage:
- `DEPTH` × `` `packet_size`` array.
- Write and read pointers, `$clog2(DEPTH)` bits, wrap naturally.
- `count`, `$clog2(DEPTH)+1` bits.

Push:
- Occurs when `mem2fifo.valid && count != DEPTH`.
- Writes the packet at `wr_ptr`; `wr_ptr` += 1.
- `mem2fifo.valid` while `count == DEPTH`: packet dropped, no state change except the overflow flag (see Configuration).

Dispatch:
- Occurs when `count != 0 && |PE_ready`.
- Selects the first set `PE_ready` bit at or after `rr_ptr`, scanning upward with wrap.
- Loads `fifo2PE[sel]` with `{1, mem[rd_ptr]}`; all other ports load 0.
- `rd_ptr` += 1; `rr_ptr` ← `(sel+1) mod N_PE`.
- No dispatch this cycle: all `fifo2PE` load 0.

Count update:
- Simultaneous push and dispatch leave `count` unchanged.
- Push at `count == DEPTH-1` and dispatch at `count == 1` are both legal in the same cycle as the other operation.

Flags:
- `full = (count >= DEPTH-SKID)`, decoded from registered `count` only.
- `empty = (count == 0)`.

Flush (`replay_iter_flag`):
- Pointers, `count` and `rr_ptr` → 0; all `fifo2PE` → 0 next cycle.
- Array contents untouched.
- Has priority over push and dispatch.

## Timing
- Reset values: `full` 0, `empty` 1, all `fifo2PE` 0; `count`, pointers and `rr_ptr` 0.
- Asserting `reset` mid-stream clears everything immediately; any in-flight `fifo2PE` valid is lost.
- Latency: `mem2fifo.valid` in cycle t → earliest `fifo2PE[i].valid` in cycle t+2.
- Throughput: one push and one dispatch per cycle.
- `full` changes at most one cycle after the push that crosses `DEPTH-SKID`.
- The controller may deliver up to `SKID` further packets after `full` rises (one SRAM-read latency plus one register); these are absorbed without loss.

## Configuration
Macro `EDGE_PACKET_FIFO_STATS_EN`.
- Defined:
  - Adds output `rx_count` (16 b): pushes accepted, wrapping.
  - Adds output `tx_count` (16 b): dispatches, wrapping.
  - Adds output `overflow` (1 b): sticky, set by any dropped push.
  - All three clear on `reset` and on `replay_iter_flag`.
- Undefined: ports and logic absent; drops are silent.

## Test plan
- Reset release, `PE_ready`=0, push packets 0x1..0x3 on consecutive cycles → `count`=3, `empty`=0, `full`=0, all `fifo2PE` valid 0.
- `DEPTH`=16, `SKID`=2, `PE_ready`=0, push 14 packets → `full`=1 the cycle after the 14th push. Push 2 more → accepted, `count`=16. Push a 17th → dropped, `overflow`=1 (stats on).
- `N_PE`=4, `PE_ready`=4'b1111, FIFO holds A,B,C,D,E → dispatched to PE 0,1,2,3,0 in consecutive cycles, each valid for exactly one cycle.
- `PE_ready`=4'b0100, `rr_ptr`=0, FIFO holds A → A appears on `fifo2PE[2]`, then `rr_ptr`=3.
- Steady push and dispatch every cycle at `count`=5 → `count` stays 5; packet order preserved across pointer wrap after 40 packets.
- `replay_iter_flag` pulsed with `count`=7 and simultaneous `mem2fifo.valid` → next cycle `count`=0, `empty`=1, no `fifo2PE` valid; the pushed packet is not stored.
